// File: rtl/nyancat_pkg.sv
// Constants shared by the nyancat renderer and frame loader: memory geometry,
// header byte layout and loader state encoding.
package nyancat_pkg;

    localparam int NUM_FRAMES   = 12;
    localparam int FRAME_W      = 64;
    localparam int FRAME_H      = 64;
    localparam int PALETTE_SIZE = 16;
    localparam int FRAME_SIZE   = FRAME_W * FRAME_H;
    localparam int FM_ADDR_W    = $clog2(NUM_FRAMES * FRAME_SIZE);

    localparam int HDR_PAL_BIT  = 7;
    localparam int HDR_IDX_MSB  = 3;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        FRM   = 2'd1,
        PAL   = 2'd2,
        DRAIN = 2'd3
    } ld_state_t;

endpackage

// File: rtl/nyancat_nibble_unpack.sv
// Holds the high nibble of an accepted frame byte for one cycle so the loader
// can issue the low and high character writes on consecutive cycles.
module nyancat_nibble_unpack (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    input  logic       last_i,
    output logic [3:0] lo_nibble_o,
    output logic [3:0] hi_nibble_o,
    output logic       hi_last_o,
    output logic       hi_pending_o,
    output logic       ready_o
);

    logic [3:0] hi_q;
    logic       last_q;
    logic       pending_q;

    // The loader never loads while a high nibble is pending, so pending lasts
    // exactly one cycle.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            hi_q      <= 4'd0;
            last_q    <= 1'b0;
            pending_q <= 1'b0;
        end else if (load_i) begin
            hi_q      <= byte_i[7:4];
            last_q    <= last_i;
            pending_q <= 1'b1;
        end else begin
            pending_q <= 1'b0;
        end
    end

    assign lo_nibble_o  = byte_i[3:0];
    assign hi_nibble_o  = hi_q;
    assign hi_last_o    = last_q;
    assign hi_pending_o = pending_q;
    assign ready_o      = ~pending_q;

endmodule

// File: rtl/nyancat_frame_loader.sv
// Stream-to-memory writer: decodes header/payload packets and writes frame
// characters or palette colors into the renderer's memories.
module nyancat_frame_loader
    import nyancat_pkg::*;
#(
    parameter int NUM_FRAMES   = nyancat_pkg::NUM_FRAMES,
    parameter int FRAME_W      = nyancat_pkg::FRAME_W,
    parameter int FRAME_H      = nyancat_pkg::FRAME_H,
    parameter int PALETTE_SIZE = nyancat_pkg::PALETTE_SIZE,
    parameter int FM_ADDR_W    = $clog2(NUM_FRAMES * FRAME_W * FRAME_H)
) (
    input  logic                 px_clk,
    input  logic                 reset,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 fm_we,
    output logic [FM_ADDR_W-1:0] fm_addr,
    output logic [3:0]           fm_wdata,
    output logic                 pm_we,
    output logic [3:0]           pm_addr,
    output logic [5:0]           pm_wdata,
    output logic                 done,
    output logic                 err,
    output logic                 busy
);

    localparam int FRAME_SZ = FRAME_W * FRAME_H;
    localparam int PIX_W    = $clog2(FRAME_SZ);
    localparam logic [PIX_W-1:0] LAST_PAIR = PIX_W'(FRAME_SZ - 2);
    localparam logic [3:0]       LAST_PAL  = 4'(PALETTE_SIZE - 1);

    ld_state_t            state_q;
    logic [FM_ADDR_W-1:0] base_q;
    logic [PIX_W-1:0]     pix_q;
    logic [3:0]           pal_cnt_q;
    logic                 fm_we_q, pm_we_q, done_q, err_q;
    logic [FM_ADDR_W-1:0] fm_addr_q;
    logic [3:0]           fm_wdata_q, pm_addr_q;
    logic [5:0]           pm_wdata_q;

    logic                 xfer, frm_load;
    logic                 hi_pending, hi_last, unpack_ready;
    logic [3:0]           lo_nibble, hi_nibble;
    logic [FM_ADDR_W-1:0] pix_addr;

    assign s_ready  = ~reset & ((state_q != FRM) | unpack_ready);
    assign xfer     = s_valid & s_ready;
    assign frm_load = xfer & (state_q == FRM);
    assign pix_addr = base_q + FM_ADDR_W'(pix_q);

    nyancat_nibble_unpack u_unpack (
        .px_clk       (px_clk),
        .reset        (reset),
        .load_i       (frm_load),
        .byte_i       (s_data),
        .last_i       (s_last),
        .lo_nibble_o  (lo_nibble),
        .hi_nibble_o  (hi_nibble),
        .hi_last_o    (hi_last),
        .hi_pending_o (hi_pending),
        .ready_o      (unpack_ready)
    );

    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q    <= HDR;
            base_q     <= '0;
            pix_q      <= '0;
            pal_cnt_q  <= 4'd0;
            fm_we_q    <= 1'b0;
            fm_addr_q  <= '0;
            fm_wdata_q <= 4'd0;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= 4'd0;
            pm_wdata_q <= 6'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fm_we_q <= 1'b0;
            pm_we_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                HDR: begin
                    if (xfer) begin
                        if (s_last) begin
                            err_q <= 1'b1;
                        end else if (s_data[HDR_PAL_BIT]) begin
                            state_q   <= PAL;
                            pal_cnt_q <= 4'd0;
                        end else if (int'(s_data[HDR_IDX_MSB:0]) < NUM_FRAMES) begin
                            state_q <= FRM;
                            base_q  <= FM_ADDR_W'(s_data[HDR_IDX_MSB:0]) * FM_ADDR_W'(FRAME_SZ);
                            pix_q   <= '0;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                FRM: begin
                    if (frm_load) begin
                        fm_we_q    <= 1'b1;
                        fm_addr_q  <= pix_addr;
                        fm_wdata_q <= lo_nibble;
                    end else if (hi_pending) begin
                        // Packet outcome is decided with the high write so done/err
                        // line up with the final memory write.
                        fm_we_q    <= 1'b1;
                        fm_addr_q  <= pix_addr + FM_ADDR_W'(1);
                        fm_wdata_q <= hi_nibble;
                        pix_q      <= pix_q + PIX_W'(2);
                        if (hi_last) begin
                            state_q <= HDR;
                            if (pix_q == LAST_PAIR) done_q <= 1'b1;
                            else                    err_q  <= 1'b1;
                        end else if (pix_q == LAST_PAIR) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                PAL: begin
                    if (xfer) begin
                        pm_we_q    <= 1'b1;
                        pm_addr_q  <= pal_cnt_q;
                        pm_wdata_q <= s_data[5:0];
                        pal_cnt_q  <= pal_cnt_q + 4'd1;
                        if (s_last) begin
                            state_q <= HDR;
                            if (pal_cnt_q == LAST_PAL) done_q <= 1'b1;
                            else                       err_q  <= 1'b1;
                        end else if (pal_cnt_q == LAST_PAL) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && s_last) begin
                        state_q <= HDR;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= HDR;
            endcase
        end
    end

    assign fm_we    = fm_we_q;
    assign fm_addr  = fm_addr_q;
    assign fm_wdata = fm_wdata_q;
    assign pm_we    = pm_we_q;
    assign pm_addr  = pm_addr_q;
    assign pm_wdata = pm_wdata_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = (state_q != HDR) | hi_pending;

endmodule
